// File: rtl/vga_pkg.sv
// Timing constants for the 640x480 display chain, shared with the timing generator.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int LINE     = 799;
  localparam int SCREEN   = 524;
  localparam int WPL      = H_ACTIVE / 8;
  localparam int AW       = 16;

  typedef logic [AW-1:0] addr_t;

  // Word address of an 8-pixel column within the current line.
  function automatic addr_t fetch_addr(input addr_t base, input logic [6:0] col);
    return base + addr_t'(col);
  endfunction

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// Host request/response bus into the framebuffer arbiter.
interface fb_scan_arbiter_if #(
  parameter int AW = 16
);

  logic          host_valid;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ready;
  logic          host_rvalid;
  logic [7:0]    host_rdata;

  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );

endinterface

// File: rtl/pix_delay.sv
// Three-stage shift register aligning a timing signal with the pixel pipeline.
module pix_delay #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [2:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {3{RST_VAL}};
    end else begin
      stage_reg <= {stage_reg[1:0], din};
    end
  end

  assign dout = stage_reg[2];

endmodule

// File: rtl/fb_scan_arbiter.sv
// Shares a single-port 1bpp framebuffer RAM between scanout fetches and a host port;
// scanout always wins, the host gets every cycle without a fetch.
module fb_scan_arbiter
  import vga_pkg::*;
(
  input  logic            clk_pix,
  input  logic            rst_pix,
  input  logic [9:0]      sx,
  input  logic [9:0]      sy,
  input  logic            de_in,
  input  logic            hsync_in,
  input  logic            vsync_in,
  fb_scan_arbiter_if.slave host,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic            pix,
  output logic            de_out,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic            frame_start
);

  localparam logic [2:0] SYNC_RST = 3'b110;

  logic          fetch;
  addr_t         line_base_reg;
  addr_t         line_base_next;
  logic          fetch_d1_reg;
  logic          rd_pend_reg;
  logic [7:0]    word_reg;
  logic [7:0]    rdata_hold_reg;
  logic [2:0]    p_d1_reg;
  logic [2:0]    p_d2_reg;
  logic          pix_raw_reg;
  logic [2:0]    sync_in;
  logic [2:0]    sync_out;

  assign fetch           = de_in && (sx[2:0] == 3'd0);
  assign host.host_ready = host.host_valid && !fetch;
  assign frame_start     = (sx == 10'(LINE)) && (sy == 10'(SCREEN));

  always_comb begin
    mem_en    = fetch || host.host_ready;
    mem_we    = 1'b0;
    mem_addr  = host.host_addr;
    mem_wdata = host.host_wdata;
    if (fetch) begin
      mem_addr = fetch_addr(line_base_reg, sx[9:3]);
    end else if (host.host_ready) begin
      mem_we = host.host_we;
    end
  end

  // line_base parks at V_ACTIVE*WPL through vertical blanking, then rewinds at frame end.
  always_comb begin
    line_base_next = line_base_reg;
    if (sx == 10'(LINE)) begin
      if (sy == 10'(SCREEN)) begin
        line_base_next = '0;
      end else if (sy < 10'(V_ACTIVE)) begin
        line_base_next = line_base_reg + addr_t'(WPL);
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      line_base_reg  <= '0;
      fetch_d1_reg   <= 1'b0;
      rd_pend_reg    <= 1'b0;
      word_reg       <= '0;
      rdata_hold_reg <= '0;
      p_d1_reg       <= '0;
      p_d2_reg       <= '0;
      pix_raw_reg    <= 1'b0;
    end else begin
      line_base_reg <= line_base_next;
      fetch_d1_reg  <= fetch;
      rd_pend_reg   <= host.host_ready && !host.host_we;
      p_d1_reg      <= sx[2:0];
      p_d2_reg      <= p_d1_reg;
      pix_raw_reg   <= word_reg[3'd7 - p_d2_reg];
      if (fetch_d1_reg) begin
        word_reg <= mem_rdata;
      end
      if (rd_pend_reg) begin
        rdata_hold_reg <= mem_rdata;
      end
    end
  end

  assign host.host_rvalid = rd_pend_reg;
  assign host.host_rdata  = rd_pend_reg ? mem_rdata : rdata_hold_reg;

  // Blanking mask uses the same 3-cycle-delayed de that leaves the block, so pix and de_out stay aligned.
  assign pix = pix_raw_reg && de_out;

  assign sync_in = {vsync_in, hsync_in, de_in};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync_delay
    pix_delay #(
      .RST_VAL (SYNC_RST[gi])
    ) u_delay (
      .clk  (clk_pix),
      .rst  (rst_pix),
      .din  (sync_in[gi]),
      .dout (sync_out[gi])
    );
  end

  assign de_out    = sync_out[0];
  assign hsync_out = sync_out[1];
  assign vsync_out = sync_out[2];

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Vector table for the RAM port / arbitration, scoreboards for the pixel stream and host reads.
module tb_fb_scan_arbiter;

  logic        clk_pix;
  logic        rst_pix;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        pix;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start;

  fb_scan_arbiter_if #(.AW(16)) hbus ();

  fb_scan_arbiter dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .sx          (sx),
    .sy          (sy),
    .de_in       (de_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .host        (hbus),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pix         (pix),
    .de_out      (de_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .frame_start (frame_start)
  );

  initial begin
    clk_pix = 1'b0;
    forever #5 clk_pix = ~clk_pix;
  end

  // Framebuffer RAM with registered read.
  logic [7:0] ram [0:65535];
  logic [7:0] ram_q;
  always @(posedge clk_pix) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  typedef struct packed {
    logic pix;
    logic de;
    logic hs;
    logic vs;
  } pe_t;

  localparam pe_t PE_RST = '{pix: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1};

  pe_t        pq[$];
  logic [7:0] rq[$];
  logic [7:0] shadow [0:65535];
  logic [15:0] lb_m;
  logic [15:0] idx_m;
  logic [7:0]  wrd_m;
  logic [2:0]  bit_m;
  pe_t         pe_cur;
  pe_t         pe_exp;

  always @(negedge clk_pix) begin
    if (pq.size() > 0) begin
      pe_exp = pq.pop_front();
      chk("pix", pix, pe_exp.pix);
      chk("de_out", de_out, pe_exp.de);
      chk("hsync_out", hsync_out, pe_exp.hs);
      chk("vsync_out", vsync_out, pe_exp.vs);
    end
    if (hbus.host_rvalid) begin
      if (rq.size() == 0) chk("rvalid_unexpected", hbus.host_rvalid, 1'b0);
      else                chk("host_rdata", hbus.host_rdata, rq.pop_front());
    end
    if (rst_pix) begin
      pq.delete();
      rq.delete();
      repeat (3) pq.push_back(PE_RST);
      lb_m = '0;
    end else begin
      idx_m = lb_m + 16'(sx[9:3]);
      wrd_m = shadow[idx_m];
      bit_m = 3'd7 - sx[2:0];
      pe_cur.pix = de_in ? wrd_m[bit_m] : 1'b0;
      pe_cur.de  = de_in;
      pe_cur.hs  = hsync_in;
      pe_cur.vs  = vsync_in;
      pq.push_back(pe_cur);
      if (hbus.host_ready && !hbus.host_we) rq.push_back(shadow[hbus.host_addr]);
      if (hbus.host_ready && hbus.host_we)  shadow[hbus.host_addr] = hbus.host_wdata;
      if (sx == 10'd799) begin
        if (sy == 10'd524)     lb_m = '0;
        else if (sy < 10'd480) lb_m = lb_m + 16'd80;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        de;
    logic        hs;
    logic        vs;
    logic        hv;
    logic        hwe;
    logic [15:0] haddr;
    logic [7:0]  hwd;
    logic        chk;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic        rdy;
    logic        fs;
  } vec_t;

  function automatic vec_t mk(input int x, input int y, input bit de, input bit hs, input bit vs,
                              input bit hv, input bit hwe, input int haddr, input int hwd,
                              input bit c, input bit en, input bit we, input int addr,
                              input bit rdy, input bit fs);
    vec_t v;
    v.sx = 10'(x);  v.sy = 10'(y);  v.de = de;  v.hs = hs;  v.vs = vs;
    v.hv = hv;  v.hwe = hwe;  v.haddr = 16'(haddr);  v.hwd = 8'(hwd);
    v.chk = c;  v.en = en;  v.we = we;  v.addr = 16'(addr);  v.rdy = rdy;  v.fs = fs;
    return v;
  endfunction

  vec_t vecs[$];

  task automatic drive(input vec_t v);
    sx = v.sx;  sy = v.sy;  de_in = v.de;  hsync_in = v.hs;  vsync_in = v.vs;
    hbus.host_valid = v.hv;  hbus.host_we = v.hwe;
    hbus.host_addr = v.haddr;  hbus.host_wdata = v.hwd;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'(i * 37 + 11);
      shadow[i] = 8'(i * 37 + 11);
    end
    ram[0]    = 8'hA5;
    shadow[0] = 8'hA5;

    // Line 0: fetch at 0 and 8, host read in a free active slot, collision at sx=8.
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int x = 1; x < 8; x++) begin
      if (x == 3) vecs.push_back(mk(x, 0, 1, 1, 1, 1, 0, 7, 0, 1, 1, 0, 7, 1, 0));
      else        vecs.push_back(mk(x, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    end
    vecs.push_back(mk(8, 0, 1, 1, 1, 1, 1, 5, 8'h77, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(9, 0, 1, 1, 1, 1, 1, 5, 8'h77, 1, 1, 1, 5, 1, 0));
    for (int x = 10; x < 16; x++) vecs.push_back(mk(x, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int x = 16; x < 20; x++) vecs.push_back(mk(x, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Blanking: host write then read-back of address 100.
    vecs.push_back(mk(700, 0, 0, 0, 1, 1, 1, 100, 8'h3C, 1, 1, 1, 100, 1, 0));
    vecs.push_back(mk(701, 0, 0, 0, 1, 1, 0, 100, 0, 1, 1, 0, 100, 1, 0));
    vecs.push_back(mk(702, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(799, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Line 1: second line base.
    vecs.push_back(mk(16, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 82, 0, 0));
    for (int x = 17; x < 24; x++) vecs.push_back(mk(x, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(799, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int y = 2; y < 479; y++) vecs.push_back(mk(799, y, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Last active word of the frame, then frame wrap.
    vecs.push_back(mk(632, 479, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 38399, 0, 0));
    for (int x = 633; x < 640; x++) vecs.push_back(mk(x, 479, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(799, 479, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(798, 524, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(799, 524, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int x = 1; x < 8; x++) vecs.push_back(mk(x, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Reset and idle inputs.
    rst_pix = 1'b1;
    drive(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk_pix);
    #1;
    rst_pix = 1'b0;
    @(negedge clk_pix);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_frame_start", frame_start, 1'b0);
    @(posedge clk_pix);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk_pix);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_mem_en", i), mem_en, vecs[i].en);
        chk($sformatf("v%0d_host_ready", i), hbus.host_ready, vecs[i].rdy);
        chk($sformatf("v%0d_frame_start", i), frame_start, vecs[i].fs);
        if (vecs[i].en) begin
          chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].we);
          chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
          if (vecs[i].we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].hwd);
        end
      end
      @(posedge clk_pix);
      #1;
    end

    // Reset mid-line at sx=300 sy=200 with a host read issued in the reset cycle.
    for (int x = 296; x < 300; x++) begin
      if (x == 299) drive(mk(x, 200, 1, 0, 0, 1, 0, 100, 0, 0, 0, 0, 0, 0, 0));
      else          drive(mk(x, 200, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk_pix);
      #1;
    end
    rst_pix = 1'b1;
    drive(mk(300, 200, 1, 0, 0, 1, 0, 101, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_pix);
    #1;
    rst_pix = 1'b0;
    drive(mk(301, 200, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_pix);
    chk("rst_pix_out", pix, 1'b0);
    chk("rst_de_out", de_out, 1'b0);
    chk("rst_hsync_out", hsync_out, 1'b1);
    chk("rst_vsync_out", vsync_out, 1'b1);
    chk("rst_host_rvalid", hbus.host_rvalid, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    @(posedge clk_pix);
    #1;
    for (int x = 302; x < 304; x++) begin
      drive(mk(x, 200, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk_pix);
      #1;
    end
    // line_base must be back at 0: word 38 even though sy=200.
    drive(mk(304, 200, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_pix);
    chk("rst_line_base_addr", mem_addr, 16'd38);
    chk("rst_line_base_en", mem_en, 1'b1);
    @(posedge clk_pix);
    #1;
    for (int x = 305; x < 312; x++) begin
      drive(mk(x, 200, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk_pix);
      #1;
    end
    drive(mk(312, 200, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (5) @(posedge clk_pix);
    #1;
    chk("read_queue_drained", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
- Shares one single-port framebuffer RAM between display scanout and a host port.
- Takes sx/sy/de/hsync/vsync from the 640x480 timing generator and fetches one 8-pixel 1bpp word every 8 active pixels.
- Serialises each word to a pixel stream; delays the syncs to match. Host accesses are granted only in cycles with no display fetch.
- Sits between the timing generator, the framebuffer RAM and the host/CPU bus.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- LINE, 799, last sx value on a line
- SCREEN, 524, last sy value in a frame
- WPL, 80, framebuffer words per line (H_ACTIVE/8)
- AW, 16, RAM word address width (covers 38400 words)

Ports:
- clk_pix  in  1  pixel clock, sole clock
- rst_pix  in  1  reset, synchronous, active-high
- sx  in  10  horizontal position from timing generator
- sy  in  10  vertical position from timing generator
- de_in  in  1  data enable from timing generator
- hsync_in  in  1  hsync from timing generator (active low)
- vsync_in  in  1  vsync from timing generator (active low)
- host_valid  in  1  host request valid
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host word address
- host_wdata  in  8  host write data
- host_ready  out  1  request accepted this cycle
- host_rvalid  out  1  read data valid
- host_rdata  out  8  read data
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid the cycle after mem_en with mem_we=0
- pix  out  1  pixel value
- de_out  out  1  de_in delayed 3 cycles
- hsync_out  out  1  hsync_in delayed 3 cycles
- vsync_out  out  1  vsync_in delayed 3 cycles
- frame_start  out  1  1-cycle pulse at sx==LINE && sy==SCREEN

Behaviour:
- Clock and reset: single clock clk_pix; synchronous active-high reset rst_pix.
- Reset values:
  - pix, de_out, host_rvalid, frame_start, mem_en, mem_we = 0
  - hsync_out, vsync_out = 1
  - line_base, word register, delay lines = 0 (sync delay stages = 1)
  - Reset mid-frame: all outputs return to reset values next cycle, and any in-flight host read is dropped (no rvalid).
- Display fetch condition: fetch = de_in && sx[2:0]==0.
- Fetch address: mem_addr = line_base + sx[9:3]; mem_en=1, mem_we=0. Combinational drive of the RAM port; a registered RAM output implies 1-cycle read data.
- line_base update, on sx==LINE:
  - sy==SCREEN: line_base <= 0
  - sy < V_ACTIVE: line_base <= line_base + WPL
  - otherwise: hold
- Word capture: word register <= mem_rdata in the cycle after a fetch.
- Pixel output:
  - pix register <= word[7 - p], where p = sx[2:0] delayed 2 cycles; MSB is the leftmost pixel.
  - pix is forced to 0 when the 2-cycle-delayed de is 0.
  - Total pixel latency is 3 cycles, matching de_out/hsync_out/vsync_out.
- Host arbitration:
  - host_ready = host_valid && !fetch (combinational). The display always wins; there is no host starvation guard.
  - In free slots, at most 7 of every 8 active cycles and all blanking cycles are available.
  - When accepted: mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - Read accepted: host_rvalid=1 the next cycle, with host_rdata=mem_rdata. host_rdata holds its value until the next read.
  - A host address ≥ V_ACTIVE*WPL is passed through unchecked.
- Simultaneous fetch and host request: the fetch goes to RAM; host_ready=0 and the host must hold its request.
- Wrap-around: the last fetch of the frame is at word 38399. line_base is 0 again before line 0 of the next frame.

Decomposition:
- Shared package (vga_pkg): timing constants H_ACTIVE, V_ACTIVE, LINE, SCREEN, WPL, shared with the timing generator.
- One sub-module, pix_delay: a 3-stage shift register used for the de/hsync/vsync alignment, instantiated with a reset-value parameter (0 for de, 1 for the syncs).

Test Plan:
- Fetch and addressing: after reset, sx=0 sy=0 de_in=1 -> mem_en=1 mem_we=0 mem_addr=0. At sx=8 -> addr 1. At sy=1 sx=16 -> addr 82.
- Pixel serialisation: RAM word 0 = 0xA5 -> pix over the cycles 3..10 after sx=0 reads 1,0,1,0,0,1,0,1; de_out is high in the same cycles.
- Arbitration collision: host_valid=1 write to addr 5 while sx=8 de_in=1 -> host_ready=0 and mem_addr=1. Next cycle -> host_ready=1, mem_we=1, mem_addr=5.
- Host read in blanking: write 0x3C to addr 100, then read addr 100 at sx=700 -> host_rvalid=1 one cycle later with host_rdata=0x3C.
- Frame wrap: at sx=799 sy=524 -> frame_start pulse. Next fetch at sx=0 sy=0 -> mem_addr=0. Last active fetch at sx=632 sy=479 -> addr 38399.
- Reset mid-line: assert rst_pix at sx=300 sy=200 -> next cycle pix=0, de_out=0, hsync_out=1, vsync_out=1, host_rvalid=0, line_base=0.
